// File: rtl/multiplier_control.sv
`default_nettype none
// ============================================================================
// Module   : multiplier_control
// Purpose  : Sequencer for an 8-bit shift-and-add signed multiplier. It steps
//            the datapath through one accumulator clear, eight ADD/SHIFT
//            pairs (the last ADD subtracts because it is the sign bit), and
//            then a HOLD state that reports Done.
// Ports    : Clk           - system clock, rising edge
//            Reset         - synchronous active-high reset
//            Run           - start request for one multiply
//            ClearA_LoadB  - idle-time clear accumulator / load multiplier
//            M             - current multiplier LSB from the datapath
//            Clr_Ld        - clear/load strobe (IDLE only)
//            ClearA        - accumulator clear at the start of a multiply
//            Add / Sub     - add / subtract multiplicand into accumulator
//            Shift         - arithmetic right shift of accumulator:multiplier
//            Done          - multiply complete (HOLD state)
// Options  : MULT_CTRL_RUN_EDGE_EN - start on the rising edge of Run and make
//            Done a single-cycle pulse. Default: level-sensitive Run, Done
//            held while Run stays high.
// Revision : 1.0 - initial release
// ============================================================================
module multiplier_control (
   input  logic Clk,
   input  logic Reset,
   input  logic Run,
   input  logic ClearA_LoadB,
   input  logic M,
   output logic Clr_Ld,
   output logic ClearA,
   output logic Add,
   output logic Sub,
   output logic Shift,
   output logic Done
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLRA  = 3'd1,
      ST_ADD   = 3'd2,
      ST_SHIFT = 3'd3,
      ST_HOLD  = 3'd4
   } state_t;

   localparam logic [2:0] C_LAST_BIT = 3'd7;

   state_t     state_q, state_d;
   logic [2:0] cnt_q, cnt_d;
   logic       start;

`ifdef MULT_CTRL_RUN_EDGE_EN
   logic       run_q, run_d;

   // Only a fresh rising edge of Run starts a multiply.
   assign start = Run & ~run_q;
   assign run_d = Run;
`else
   assign start = Run;
`endif

   // ------------------------------------------------------------------------
   // Next-state and bit-counter logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_CLRA;
               cnt_d   = 3'd0;
            end
         end
         ST_CLRA: begin
            state_d = ST_ADD;
            cnt_d   = 3'd0;
         end
         ST_ADD: begin
            state_d = ST_SHIFT;
         end
         ST_SHIFT: begin
            // The counter stops at 7 on the final shift, so it never wraps.
            if (cnt_q == C_LAST_BIT) begin
               state_d = ST_HOLD;
            end else begin
               state_d = ST_ADD;
               cnt_d   = cnt_q + 3'd1;
            end
         end
         ST_HOLD: begin
`ifdef MULT_CTRL_RUN_EDGE_EN
            state_d = ST_IDLE;
`else
            if (!Run) begin
               state_d = ST_IDLE;
            end
`endif
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = 3'd0;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= 3'd0;
`ifdef MULT_CTRL_RUN_EDGE_EN
         run_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
`ifdef MULT_CTRL_RUN_EDGE_EN
         run_q   <= run_d;
`endif
      end
   end

   // ------------------------------------------------------------------------
   // Outputs. ClearA, Shift and Done decode the state register directly;
   // Add/Sub follow M within the ADD cycle. The datapath strobes are masked
   // while Reset is high so a reset that lands mid-multiply never lets a
   // stale strobe reach the datapath. Clr_Ld depends only on IDLE and the
   // inputs, with Run taking precedence over a clear/load request.
   // ------------------------------------------------------------------------
   assign Clr_Ld = (state_q == ST_IDLE) & ClearA_LoadB & ~Run;
   assign ClearA = ~Reset & (state_q == ST_CLRA);
   assign Add    = ~Reset & (state_q == ST_ADD) & M & (cnt_q != C_LAST_BIT);
   assign Sub    = ~Reset & (state_q == ST_ADD) & M & (cnt_q == C_LAST_BIT);
   assign Shift  = ~Reset & (state_q == ST_SHIFT);
   assign Done   = ~Reset & (state_q == ST_HOLD);

endmodule
`default_nettype wire

// File: doc/multiplier_control.md
MULTIPLIER_CONTROL -- requirements
Module: multiplier_control

Interface
REQ-001 SHALL have port Clk, input, 1, single system clock; all state updates on the rising edge.
REQ-002 SHALL have port Reset, input, 1, reset; synchronous, active-high.
REQ-003 SHALL have port Run, input, 1, start request for one 8-bit multiply.
REQ-004 SHALL have port ClearA_LoadB, input, 1, idle-time request to clear the accumulator and load the multiplier.
REQ-005 SHALL have port M, input, 1, current multiplier LSB from the arithmetic datapath.
REQ-006 SHALL have port Clr_Ld, output, 1, clear/load strobe to the datapath.
REQ-007 SHALL have port ClearA, output, 1, accumulator clear strobe at the start of a multiply.
REQ-008 SHALL have port Add, output, 1, add multiplicand into the accumulator.
REQ-009 SHALL have port Sub, output, 1, subtract multiplicand from the accumulator (sign-bit step).
REQ-010 SHALL have port Shift, output, 1, arithmetic right shift of the accumulator/multiplier pair.
REQ-011 SHALL have port Done, output, 1, multiply complete.

Function
REQ-012 SHALL implement states IDLE, CLRA, ADD, SHIFT and HOLD, plus a 3-bit bit counter cnt.
REQ-013 In IDLE, when the start condition holds (REQ-026/027), the FSM SHALL go to CLRA on the next edge with cnt=0.
REQ-014 In IDLE, SHALL drive Clr_Ld=ClearA_LoadB & ~Run, combinationally; Run takes precedence over ClearA_LoadB.
REQ-015 CLRA SHALL last exactly 1 cycle with ClearA=1 and then go to ADD.
REQ-016 In ADD, SHALL drive Add=M&(cnt!=7) and Sub=M&(cnt==7), combinationally from M; ADD then goes to SHIFT.
REQ-017 In SHIFT, SHALL drive Shift=1 and go to HOLD if cnt==7; otherwise SHALL go to ADD and increment cnt.
REQ-018 Latency: CLRA SHALL occur in cycle 1 after the start edge, ADD/SHIFT pairs in cycles 2-17, and HOLD from cycle 18.
REQ-019 SHALL assert Done=1 only in HOLD.
REQ-020 Add, Sub, Shift, ClearA and Clr_Ld SHALL be mutually exclusive in every cycle.
REQ-021 SHALL ignore Run and ClearA_LoadB in CLRA, ADD and SHIFT; there is no abort except Reset.
REQ-022 cnt SHALL not wrap during a multiply; it is reset to 0 on entry to CLRA.

Reset
REQ-023 Reset=1 at an edge SHALL force IDLE and cnt=0, from any state including mid-multiply.
REQ-024 While in reset and in the cycle after, SHALL drive ClearA, Add, Sub, Shift and Done to 0, and Clr_Ld per REQ-014.
REQ-025 Reset SHALL dominate Run when both are asserted at the same edge.

Configuration
REQ-026 Without MULT_CTRL_RUN_EDGE_EN:
- start condition is Run==1 while in IDLE;
- HOLD SHALL persist while Run==1;
- HOLD SHALL return to IDLE on the first edge with Run==0.
REQ-027 With MULT_CTRL_RUN_EDGE_EN defined:
- SHALL register Run_q, reset to 0;
- start condition is Run & ~Run_q while in IDLE;
- HOLD SHALL last exactly 1 cycle (Done pulse) and then return to IDLE regardless of Run.

Verification
REQ-028 Reset=1 for 2 cycles, all inputs 0 -> IDLE; ClearA/Add/Sub/Shift/Done/Clr_Ld all 0.
REQ-029 IDLE, ClearA_LoadB=1, Run=0 -> Clr_Ld=1 that cycle, state stays IDLE; with Run=1 also asserted -> Clr_Ld=0 and CLRA follows.
REQ-030 M held 1, Run asserted -> cycle 1 ClearA=1; Add=1 in cycles 2,4,...,14; Sub=1 in cycle 16; Shift=1 in cycles 3,5,...,17; Done=1 from cycle 18.
REQ-031 M held 0, Run asserted -> no Add or Sub, exactly 8 Shift pulses (cycles 3-17 odd), Done at cycle 18.
REQ-032 Reset asserted at the edge ending cycle 9 (SHIFT, cnt=3) -> next cycle IDLE, all strobes 0, and a new Run restarts at CLRA.
REQ-033 Run held high for 30 cycles -> without macro: Done stays 1 until Run falls, no second multiply; with macro: 1-cycle Done, and no restart until Run falls and rises again.
